// File: rtl/td4_inst_encoder_if.sv
// Field-set handshake between a program builder and the TD4 instruction encoder.
// The master presents decoded control fields; the slave consumes them on valid & ready.
interface td4_inst_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ds;
  logic [3:0] in_load;
  logic       in_cond;
  logic [3:0] in_imm;

  modport master (
    output in_valid, in_ds, in_load, in_cond, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_ds, in_load, in_cond, in_imm,
    output in_ready
  );
endinterface

// File: rtl/td4_inst_encoder.sv
// Re-encodes decoded TD4 control fields into 8-bit instruction words and fills a
// 2**ADDR_W-entry program store that the fetch path reads with one-cycle latency.
module td4_inst_encoder #(
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  td4_inst_encoder_if.slave   bus,
  output logic                err,
  output logic [ADDR_W:0]     wcount,
  output logic                prog_done,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [7:0]          rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_wcount;
  logic              r_err;
  logic              r_prog_done;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_mem [DEPTH];

  logic              w_ready;
  logic              w_accept;
  logic              w_legal;
  logic [3:0]        w_opcode;
  logic [7:0]        w_word;
  logic              w_last;

  // Ready drops combinationally while clear is held so a clear never races an accept.
  assign w_ready  = (r_state == ST_LOAD) && !clear;
  assign w_accept = bus.in_valid && w_ready;
  assign w_word   = {w_opcode, bus.in_imm};
  assign w_last   = (r_wptr == ADDR_W'(DEPTH - 1));

  // Field-to-opcode encoder; anything not matching a TD4 instruction is illegal.
  always_comb begin
    w_legal  = 1'b0;
    w_opcode = 4'h0;
    case (bus.in_load)
      4'b0001: begin
        w_legal  = 1'b1;
        w_opcode = {2'b00, bus.in_ds};
      end
      4'b0010: begin
        w_legal  = 1'b1;
        w_opcode = {2'b01, bus.in_ds};
      end
      4'b0100: begin
        // OUT only exists sourced from B (1001) or immediate (1011).
        w_legal  = bus.in_ds[0];
        w_opcode = {2'b10, bus.in_ds};
      end
      4'b1000: begin
        w_legal  = (bus.in_ds == 2'b11);
        w_opcode = bus.in_cond ? 4'b1110 : 4'b1111;
      end
      default: begin
        w_legal  = 1'b0;
        w_opcode = 4'h0;
      end
    endcase
  end

  // Write-side control FSM, program store and registered read port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_LOAD;
      r_wptr      <= '0;
      r_wcount    <= '0;
      r_err       <= 1'b0;
      r_prog_done <= 1'b0;
      r_rd_data   <= FILL;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= FILL;
      end
    end else begin
      r_rd_data <= r_mem[rd_addr];
      r_err     <= 1'b0;
      if (clear) begin
        r_state     <= ST_LOAD;
        r_wptr      <= '0;
        r_wcount    <= '0;
        r_prog_done <= 1'b0;
      end else if (w_accept) begin
        if (w_legal) begin
          r_mem[r_wptr] <= w_word;
          r_wptr        <= ADDR_W'(r_wptr + 1'b1);
          r_wcount      <= (ADDR_W + 1)'(r_wcount + 1'b1);
          if (w_last) begin
            r_state     <= ST_FULL;
            r_prog_done <= 1'b1;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign err          = r_err;
  assign wcount       = r_wcount;
  assign prog_done    = r_prog_done;
  assign rd_data      = r_rd_data;

endmodule

// File: tb/tb_td4_inst_encoder.sv
// Directed self-checking bench for td4_inst_encoder with hand-computed expectations.
module tb_td4_inst_encoder;

  logic       clk;
  logic       rstn;
  logic       clear;
  logic       err;
  logic [4:0] wcount;
  logic       prog_done;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  int checks;
  int errors;

  td4_inst_encoder_if bus ();

  td4_inst_encoder #(.ADDR_W(4), .FILL(8'h00)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .bus       (bus.slave),
    .err       (err),
    .wcount    (wcount),
    .prog_done (prog_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one field set for a single clock edge; returns #1 after that edge.
  task automatic push(input logic [1:0] ds, input logic [3:0] load,
                      input logic cond, input logic [3:0] imm);
    bus.in_valid = 1'b1;
    bus.in_ds    = ds;
    bus.in_load  = load;
    bus.in_cond  = cond;
    bus.in_imm   = imm;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    @(posedge clk);
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rstn         = 1'b0;
    clear        = 1'b0;
    rd_addr      = '0;
    bus.in_valid = 1'b0;
    bus.in_ds    = '0;
    bus.in_load  = '0;
    bus.in_cond  = 1'b0;
    bus.in_imm   = '0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_done",  32'(prog_done),    32'd0);
    chk("rst_err",   32'(err),          32'd0);
    chk("rst_wcount", 32'(wcount),      32'd0);
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "rst_mem");

    // Basic legal encodings
    push(2'b11, 4'b0001, 1'b0, 4'h3);
    push(2'b01, 4'b0100, 1'b0, 4'h0);
    push(2'b11, 4'b1000, 1'b1, 4'h2);
    chk("wcount3", 32'(wcount), 32'd3);
    chk("err_legal", 32'(err), 32'd0);
    rd(4'd0, 8'h33, "mem0_mov_a_imm");
    rd(4'd1, 8'h90, "mem1_out_b");
    rd(4'd2, 8'hE2, "mem2_jnc");

    // Illegal combinations
    push(2'b00, 4'b0011, 1'b0, 4'h5);
    chk("err_nonhot", 32'(err), 32'd1);
    chk("wcount_nonhot", 32'(wcount), 32'd3);
    tick();
    chk("err_pulse_end", 32'(err), 32'd0);
    push(2'b00, 4'b0100, 1'b0, 4'h5);
    chk("err_out_a", 32'(err), 32'd1);
    push(2'b01, 4'b1000, 1'b0, 4'h5);
    chk("err_jmp_ds", 32'(err), 32'd1);
    push(2'b00, 4'b0000, 1'b0, 4'h5);
    chk("err_zero_load", 32'(err), 32'd1);
    chk("wcount_illegal", 32'(wcount), 32'd3);
    rd(4'd3, 8'h00, "mem3_untouched");

    // More legal encodings
    push(2'b11, 4'b0100, 1'b0, 4'hA);
    push(2'b10, 4'b0010, 1'b0, 4'h5);
    chk("wcount5", 32'(wcount), 32'd5);
    rd(4'd3, 8'hBA, "mem3_out_imm");
    rd(4'd4, 8'h65, "mem4_in_b");

    // Restart and fill the whole store
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_wcount", 32'(wcount), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("done_before_last", 32'(prog_done), 32'd0);
      push(2'b11, 4'b1000, 1'b0, 4'(i));
    end
    chk("full_done",   32'(prog_done),    32'd1);
    chk("full_ready",  32'(bus.in_ready), 32'd0);
    chk("full_wcount", 32'(wcount),       32'd16);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'hF0 | 8'(i), "full_mem");
    push(2'b11, 4'b0001, 1'b0, 4'h5);
    chk("full_ignore_wcount", 32'(wcount), 32'd16);
    chk("full_ignore_err", 32'(err), 32'd0);
    rd(4'd0, 8'hF0, "full_ignore_mem0");

    // Clear while FULL with valid asserted
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_load  = 4'b0001;
    #1;
    chk("clear_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clr_wcount", 32'(wcount),       32'd0);
    chk("clr_done",   32'(prog_done),    32'd0);
    chk("clr_ready",  32'(bus.in_ready), 32'd1);
    chk("clr_err",    32'(err),          32'd0);
    rd(4'd0, 8'hF0, "clr_mem0_kept");
    push(2'b01, 4'b0001, 1'b0, 4'h7);
    rd(4'd0, 8'h17, "overwrite_mem0");

    // Asynchronous reset mid-load
    for (int i = 0; i < 4; i++) push(2'b11, 4'b0010, 1'b0, 4'(i));
    chk("pre_rst_wcount", 32'(wcount), 32'd5);
    rd_addr = 4'd0;
    tick();
    chk("pre_rst_rd", 32'(rd_data), 32'h17);
    #2 rstn = 1'b0;
    #1;
    chk("async_wcount", 32'(wcount),    32'd0);
    chk("async_done",   32'(prog_done), 32'd0);
    chk("async_rd",     32'(rd_data),   32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    rd(4'd0, 8'h00, "async_mem0");
    rd(4'd1, 8'h00, "async_mem1");
    rd(4'd4, 8'h00, "async_mem4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_inst_encoder.md
Name: td4_inst_encoder

Overview:
Inverse of the CPU instruction decoder. Accepts decoded control fields (data select, one-hot register load, jump condition, immediate), re-encodes them into 8-bit TD4 instruction words, and writes them sequentially into a 16-entry program store. The CPU fetch path reads this store. The block is the program-building front end that feeds the fetch/decode path. Illegal field combinations are rejected and flagged.

Parameters:
ADDR_W, 4, program address width; depth = 2**ADDR_W (matches 4-bit PC)
FILL, 8'h00, reset/unwritten content of every program entry

Ports:
clk  input  1  clock, all state updates on posedge
rstn  input  1  asynchronous active-low reset (negedge rstn)
clear  input  1  synchronous restart of the write pointer; memory contents retained
in_valid  input  1  field set on in_* is presented
in_ready  output  1  block can accept a field set this cycle
in_ds  input  2  data select (00 A, 01 B, 10 IN, 11 zero)
in_load  input  4  one-hot load {3 PC, 2 OUT, 1 B, 0 A}
in_cond  input  1  with in_load=1000: 1 = JNC, 0 = JMP
in_imm  input  4  immediate nibble, becomes instruction bits [3:0]
err  output  1  one-cycle pulse: last accepted field set was illegal
wcount  output  ADDR_W+1  number of instructions written since reset/clear
prog_done  output  1  store full
rd_addr  input  ADDR_W  fetch address
rd_data  output  8  registered instruction at rd_addr

Behaviour:
- Reset (rstn low, asynchronous): state LOAD, write pointer 0, wcount 0, err 0, prog_done 0, rd_data FILL, all entries FILL.
- States: LOAD (in_ready = ~clear), FULL (in_ready = 0).
- Accept on posedge when in_valid & in_ready.
- Opcode encoding, combinational from fields:
  - load 0001 -> {00, ds}, any ds.
  - load 0010 -> {01, ds}, any ds.
  - load 0100 -> ds 01 gives 1001; ds 11 gives 1011; ds 00/10 illegal.
  - load 1000 -> ds must be 11; opcode 1110 if in_cond=1, 1111 if in_cond=0.
  - Any non-one-hot load (including 0000) is illegal.
- Word written = {opcode, in_imm}.
- Legal accept: mem[wptr] <= word; wptr and wcount increment. If wptr was depth-1, next state is FULL and prog_done goes to 1 the same edge; wptr wraps to 0.
- Illegal accept: no write; wptr and wcount unchanged; err = 1 for exactly the next cycle. Still consumes the handshake.
- FULL: in_valid is ignored and err stays 0. Only clear or reset leaves FULL.
- clear (synchronous, priority over accept): wptr 0, wcount 0, prog_done 0, err 0, state LOAD. No write that cycle; memory untouched.
- Read: rd_data <= mem[rd_addr] each posedge, 1-cycle latency, independent of write state.
- Read/write same address, same edge: rd_data returns the old content.
- in_* fields are don't-care when in_valid = 0.

Test Plan:
1. Release reset -> in_ready=1, prog_done=0, err=0, wcount=0, rd_data=8'h00 for every rd_addr.
2. Push ds=11/load=0001/imm=3, then ds=01/load=0100/imm=0, then ds=11/load=1000/cond=1/imm=2 -> entries 0,1,2 read 8'h33, 8'h90, 8'hE2 one cycle after rd_addr; wcount=3.
3. Push load=0011, then ds=00/load=0100 -> err pulses one cycle after each; wcount unchanged; addressed entries stay 8'h00.
4. Push 16 legal words (ds=11/load=1000/cond=0/imm=i) -> entry i reads 8'hF0|i; prog_done=1, in_ready=0, wcount=16. A 17th in_valid changes nothing.
5. Assert clear with in_valid=1 in FULL -> next cycle wcount=0, prog_done=0, in_ready=1; entry 0 still 8'hF0. Next push overwrites entry 0.
6. Drop rstn asynchronously mid-load (wcount=5) -> outputs reset immediately without a clock edge; entries return to 8'h00.
